// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle-fill drawing engine feeding the frame-buffer write port.
//   Accepts one command (x, y, w, h, color) over valid/ready, clips it to the
//   HD x VD visible area and writes one pixel per clock in raster order.
//   Optional macro VGA_RECT_OUTLINE_EN: honour cmd_outline_i (perimeter only).
// Ports:
//   clk, arstn            clock, synchronous active-low reset
//   cmd_valid_i/ready_o   command handshake
//   cmd_x_i, cmd_y_i      top-left corner
//   cmd_w_i, cmd_h_i      size in pixels / lines
//   cmd_color_i           2-bit color code
//   cmd_outline_i         outline-only request (optional feature)
//   we_o, color_o         pixel write strobe and color
//   addr_x_o, addr_y_o    pixel address
//   busy_o, done_o        command in progress, one-cycle completion pulse
module vga_rect_fill #(
  parameter int unsigned HD         = 1280,
  parameter int unsigned VD         = 1024,
  parameter int unsigned COORD_BITS = 11
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [COORD_BITS-1:0] cmd_x_i,
  input  logic [COORD_BITS-1:0] cmd_y_i,
  input  logic [COORD_BITS-1:0] cmd_w_i,
  input  logic [COORD_BITS-1:0] cmd_h_i,
  input  logic [1:0]            cmd_color_i,
  input  logic                  cmd_outline_i,
  output logic                  we_o,
  output logic [1:0]            color_o,
  output logic [COORD_BITS-1:0] addr_x_o,
  output logic [COORD_BITS-1:0] addr_y_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [COORD_BITS:0] HD_L = (COORD_BITS+1)'(HD);
  localparam logic [COORD_BITS:0] VD_L = (COORD_BITS+1)'(VD);

  typedef enum logic [1:0] {IDLE, CLIP, DRAW, DONE} state_t;
  state_t state, state_nxt;

  logic [COORD_BITS-1:0] x0, y0, w_q, h_q, cur_x, cur_y;
  logic [COORD_BITS-1:0] cur_x_nxt, cur_y_nxt;
  logic [COORD_BITS:0]   x_end, y_end;
  logic [COORD_BITS:0]   x_sum, y_sum, x_last_c, y_last_c;
  logic [1:0]            color_q;
  logic                  empty, last_col, last_row, accept;

`ifdef VGA_RECT_OUTLINE_EN
  logic outline_q;
`else
  logic unused_outline;
  assign unused_outline = cmd_outline_i;
`endif

  assign accept = cmd_valid_i && cmd_ready_o;

  // Clip math is one bit wider than the coordinates so x+w never wraps.
  always_comb begin
    x_sum    = {1'b0, x0} + {1'b0, w_q};
    y_sum    = {1'b0, y0} + {1'b0, h_q};
    x_last_c = ((x_sum > HD_L) ? HD_L : x_sum) - 1'b1;
    y_last_c = ((y_sum > VD_L) ? VD_L : y_sum) - 1'b1;
    empty    = (w_q == '0) || (h_q == '0) ||
               ({1'b0, x0} >= HD_L) || ({1'b0, y0} >= VD_L);
  end

  always_comb begin
    last_col  = ({1'b0, cur_x} == x_end);
    last_row  = ({1'b0, cur_y} == y_end);
    cur_x_nxt = cur_x + 1'b1;
    cur_y_nxt = cur_y;
    if (last_col) begin
      cur_x_nxt = x0;
      cur_y_nxt = cur_y + 1'b1;
    end
`ifdef VGA_RECT_OUTLINE_EN
    // Interior rows of an outline only visit x0 and x_end.
    else if (outline_q && (cur_y != y0) && !last_row) begin
      cur_x_nxt = x_end[COORD_BITS-1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!arstn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CLIP;
      CLIP: state_nxt = empty ? DONE : DRAW;
      DRAW: if (last_col && last_row) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers lag the FSM by one cycle: a DRAW cycle's pixel is
  // presented on the following cycle, and DONE shows up as done_o after it.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      x0          <= '0;
      y0          <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      x_end       <= '0;
      y_end       <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      cmd_ready_o <= 1'b1;
      we_o        <= 1'b0;
      color_o     <= '0;
      addr_x_o    <= '0;
      addr_y_o    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
`ifdef VGA_RECT_OUTLINE_EN
      outline_q   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && accept) begin
        x0      <= cmd_x_i;
        y0      <= cmd_y_i;
        w_q     <= cmd_w_i;
        h_q     <= cmd_h_i;
        color_q <= cmd_color_i;
`ifdef VGA_RECT_OUTLINE_EN
        outline_q <= cmd_outline_i;
`endif
      end
      if (state == CLIP) begin
        x_end <= x_last_c;
        y_end <= y_last_c;
        cur_x <= x0;
        cur_y <= y0;
      end
      if (state == DRAW) begin
        cur_x    <= cur_x_nxt;
        cur_y    <= cur_y_nxt;
        addr_x_o <= cur_x;
        addr_y_o <= cur_y;
        color_o  <= color_q;
      end
      we_o        <= (state == DRAW);
      done_o      <= (state == DONE);
      cmd_ready_o <= (state_nxt == IDLE);
      busy_o      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  logic        arstn;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [10:0] cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i;
  logic [1:0]  cmd_color_i;
  logic        cmd_outline_i;
  logic        we_o;
  logic [1:0]  color_o;
  logic [10:0] addr_x_o, addr_y_o;
  logic        busy_o, done_o;

  vga_rect_fill #(.HD(1280), .VD(1024), .COORD_BITS(11)) dut (
    .clk(clk), .arstn(arstn),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .cmd_w_i(cmd_w_i), .cmd_h_i(cmd_h_i),
    .cmd_color_i(cmd_color_i), .cmd_outline_i(cmd_outline_i),
    .we_o(we_o), .color_o(color_o), .addr_x_o(addr_x_o), .addr_y_o(addr_y_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int c; int cyc;} wr_t;
  typedef struct {int x; int y; int w; int h; int c; int o;
                  int n; int fx; int fy; int lx; int ly;} vec_t;

  wr_t   wq[$];
  int    acc_q[$];
  int    done_q[$];
  int    cyc = 0;
  int    n_pass = 0;
  int    n_total = 0;
  vec_t  vecs[9];

  always @(posedge clk) begin
    if (arstn && cmd_valid_i && cmd_ready_o) acc_q.push_back(cyc + 1);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    wr_t w;
    if (we_o) begin
      w.x = int'(addr_x_o); w.y = int'(addr_y_o); w.c = int'(color_o); w.cyc = cyc;
      wq.push_back(w);
    end
    if (done_o) done_q.push_back(cyc);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic issue(input int x, input int y, input int w, input int h,
                       input int c, input int o);
    int n0 = acc_q.size();
    int k;
    cmd_x_i = 11'(x); cmd_y_i = 11'(y); cmd_w_i = 11'(w); cmd_h_i = 11'(h);
    cmd_color_i = 2'(c); cmd_outline_i = 1'(o);
    cmd_valid_i = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (acc_q.size() > n0) break;
    end
    cmd_valid_i = 1'b0;
    if (k == 50) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int cnt);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (done_q.size() >= cnt) break;
      @(negedge clk); #1;
    end
    if (k == 3000) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_seq(input string nm, input int xs[$], input int ys[$]);
    int bad = 0;
    if (wq.size() != xs.size()) bad = 1000;
    else foreach (xs[i]) if (wq[i].x != xs[i] || wq[i].y != ys[i]) bad++;
    chk(nm, bad, 0);
  endtask

  initial begin
    int sx[$];
    int sy[$];
    int bad_c, bad_b;
    arstn = 1'b0; cmd_valid_i = 1'b0;
    cmd_x_i = '0; cmd_y_i = '0; cmd_w_i = '0; cmd_h_i = '0;
    cmd_color_i = '0; cmd_outline_i = 1'b0;

    vecs[0] = '{10, 20, 3, 2, 2, 0, 6, 10, 20, 12, 21};
    vecs[1] = '{1278, 1022, 5, 5, 1, 0, 4, 1278, 1022, 1279, 1023};
    vecs[2] = '{7, 7, 0, 4, 1, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{1280, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{0, 1023, 3, 1, 3, 0, 3, 0, 1023, 2, 1023};
`ifdef VGA_RECT_OUTLINE_EN
    vecs[5] = '{0, 0, 4, 4, 3, 1, 12, 0, 0, 3, 3};
`else
    vecs[5] = '{0, 0, 4, 4, 3, 1, 16, 0, 0, 3, 3};
`endif
    vecs[6] = '{100, 1024, 2, 2, 1, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{2047, 2047, 2047, 2047, 2, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{5, 6, 1, 3, 0, 0, 3, 5, 6, 5, 8};

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", int'(cmd_ready_o), 1);
    chk("rst_we", int'(we_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_addr", int'(addr_x_o) + int'(addr_y_o), 0);
    chk("rst_color", int'(color_o), 0);
    arstn = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      wq.delete(); acc_q.delete(); done_q.delete();
      issue(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c, vecs[i].o);
      wait_done(1);
      chk($sformatf("v%0d_count", i), wq.size(), vecs[i].n);
      if (wq.size() > 0 && vecs[i].n > 0 && done_q.size() > 0) begin
        chk($sformatf("v%0d_first_x", i), wq[0].x, vecs[i].fx);
        chk($sformatf("v%0d_first_y", i), wq[0].y, vecs[i].fy);
        chk($sformatf("v%0d_last_x", i), wq[$].x, vecs[i].lx);
        chk($sformatf("v%0d_last_y", i), wq[$].y, vecs[i].ly);
        chk($sformatf("v%0d_first_lat", i), wq[0].cyc - acc_q[0], 2);
        chk($sformatf("v%0d_burst_len", i), wq[$].cyc - wq[0].cyc + 1, vecs[i].n);
        chk($sformatf("v%0d_done_lat", i), done_q[0] - wq[$].cyc, 1);
      end else if (done_q.size() > 0) begin
        chk($sformatf("v%0d_done_lat", i), done_q[0] - acc_q[0], 2);
      end
      bad_c = 0; bad_b = 0;
      foreach (wq[j]) begin
        if (wq[j].c != vecs[i].c) bad_c++;
        if (wq[j].x >= 1280 || wq[j].y >= 1024) bad_b++;
      end
      chk($sformatf("v%0d_color", i), bad_c, 0);
      chk($sformatf("v%0d_bounds", i), bad_b, 0);
      case (i)
        0: begin
          sx = '{10, 11, 12, 10, 11, 12}; sy = '{20, 20, 20, 21, 21, 21};
          chk_seq("v0_order", sx, sy);
        end
        1: begin
          sx = '{1278, 1279, 1278, 1279}; sy = '{1022, 1022, 1023, 1023};
          chk_seq("v1_order", sx, sy);
        end
        5: begin
`ifdef VGA_RECT_OUTLINE_EN
          sx = '{0, 1, 2, 3, 0, 3, 0, 3, 0, 1, 2, 3};
          sy = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
`else
          sx = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
          sy = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
`endif
          chk_seq("v5_order", sx, sy);
        end
        default: ;
      endcase
      @(negedge clk); #1;
      chk($sformatf("v%0d_busy_after", i), int'(busy_o), 0);
      chk($sformatf("v%0d_ready_after", i), int'(cmd_ready_o), 1);
    end

    // Valid held high across two commands: second waits for ready after DONE.
    wq.delete(); acc_q.delete(); done_q.delete();
    cmd_x_i = 11'd0; cmd_y_i = 11'd0; cmd_w_i = 11'd1; cmd_h_i = 11'd1;
    cmd_color_i = 2'd1; cmd_outline_i = 1'b0; cmd_valid_i = 1'b1;
    for (int k = 0; k < 50 && acc_q.size() < 1; k++) begin @(posedge clk); #2; end
    cmd_x_i = 11'd5; cmd_y_i = 11'd5;
    for (int k = 0; k < 50 && acc_q.size() < 2; k++) begin @(posedge clk); #2; end
    cmd_valid_i = 1'b0;
    wait_done(2);
    repeat (5) @(negedge clk);
    #1;
    chk("q_accepts", acc_q.size(), 2);
    chk("q_writes", wq.size(), 2);
    chk("q_dones", done_q.size(), 2);
    if (acc_q.size() == 2 && done_q.size() >= 1)
      chk("q_accept2_after_done", acc_q[1] - done_q[0], 1);
    sx = '{0, 5}; sy = '{0, 5};
    chk_seq("q_order", sx, sy);

    // Reset asserted during the 3rd write of a 4x4 fill.
    wq.delete(); acc_q.delete(); done_q.delete();
    issue(50, 60, 4, 4, 2, 0);
    for (int k = 0; k < 50 && wq.size() < 3; k++) begin @(negedge clk); #1; end
    chk("r_third_write_x", (wq.size() == 3) ? wq[2].x : -1, 52);
    arstn = 1'b0;
    @(negedge clk); #1;
    arstn = 1'b1;
    chk("r_we_low", int'(we_o), 0);
    chk("r_ready_high", int'(cmd_ready_o), 1);
    chk("r_busy_low", int'(busy_o), 0);
    repeat (10) @(negedge clk);
    #1;
    chk("r_no_done", done_q.size(), 0);
    chk("r_writes_stopped", wq.size(), 3);
    wq.delete(); acc_q.delete(); done_q.delete();
    issue(9, 9, 1, 1, 3, 0);
    wait_done(1);
    chk("r_post_count", wq.size(), 1);
    sx = '{9}; sy = '{9};
    chk_seq("r_post_addr", sx, sy);
    if (wq.size() == 1) chk("r_post_color", wq[0].c, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
